// File: rtl/ysyx_22050019_ifu_fetch.sv
// Instruction-fetch stage: holds the PC, reads 64-bit words from instruction
// memory over a valid/ready handshake, and hands one 32-bit instruction at a
// time to decode, taking decode's redirect when the instruction is accepted.
module ysyx_22050019_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_arvalid,
  output logic [63:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_pc_o,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        fetch_err_o,
  output logic [63:0] instret_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  // Clear while rst is held so no request is offered during reset; the first
  // request appears in the first cycle after rst deasserts.
  logic        armed;

  // Handshake strobes depend only on registered state.
  assign mem_araddr   = {pc[63:3], 3'b000};
  assign mem_arvalid  = (state == S_REQ) && armed;
  assign mem_rready   = (state == S_WAIT);
  assign inst_valid_o = (state == S_HOLD);

  // Fetch state machine with PC, instruction, error and retire-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_REQ;
      armed          <= 1'b0;
      pc             <= RESET_PC;
      inst_o         <= '0;
      inst_addr_pc_o <= RESET_PC;
      fetch_err_o    <= 1'b0;
      instret_o      <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_REQ: begin
          if (mem_arvalid && mem_arready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (mem_rresp == 2'b00) begin
              inst_o         <= pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
              inst_addr_pc_o <= pc;
              state          <= S_HOLD;
            end else begin
              fetch_err_o <= 1'b1;
              inst_o      <= NOP_INST;
              state       <= S_ERR;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready_i) begin
            instret_o <= instret_o + 64'd1;
            if (redirect_i) begin
              // Target is loaded even when misaligned so it can be inspected.
              pc <= redirect_pc_i;
              if (redirect_pc_i[1:0] != 2'b00) begin
                fetch_err_o <= 1'b1;
                state       <= S_ERR;
              end else begin
                state <= S_REQ;
              end
            end else begin
              pc    <= pc + 64'd4;
              state <= S_REQ;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_ifu_fetch.sv
// Directed bench for the fetch stage: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_ysyx_22050019_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_arvalid;
  logic [63:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_pc_o;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        fetch_err_o;
  logic [63:0] instret_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ysyx_22050019_ifu_fetch #(
    .RESET_PC (64'h0000_0000_8000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_arvalid    (mem_arvalid),
    .mem_araddr     (mem_araddr),
    .mem_arready    (mem_arready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_rresp      (mem_rresp),
    .mem_rready     (mem_rready),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_addr_pc_o (inst_addr_pc_o),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .fetch_err_o    (fetch_err_o),
    .instret_o      (instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_rresp = 2'b00; inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // Reset state
    nc(); nc();
    chk("rst_arvalid", 64'(mem_arvalid), 64'd0);
    chk("rst_rready", 64'(mem_rready), 64'd0);
    chk("rst_ivalid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_pc", inst_addr_pc_o, 64'h8000_0000);
    chk("rst_araddr", mem_araddr, 64'h8000_0000);
    chk("rst_err", 64'(fetch_err_o), 64'd0);
    chk("rst_instret", instret_o, 64'd0);

    // Release reset, arready held low for 5 cycles
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nc();
      chk("stall_arvalid", 64'(mem_arvalid), 64'd1);
      chk("stall_araddr", mem_araddr, 64'h8000_0000);
      chk("stall_rready", 64'(mem_rready), 64'd0);
    end
    mem_arready = 1'b1;
    nc();
    mem_arready = 1'b0;
    chk("acc1_rready", 64'(mem_rready), 64'd1);
    chk("acc1_arvalid", 64'(mem_arvalid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h00000093_00100113;
    nc();
    mem_rvalid = 1'b0;
    chk("f1_valid", 64'(inst_valid_o), 64'd1);
    chk("f1_inst", 64'(inst_o), 64'h0010_0113);
    chk("f1_pc", inst_addr_pc_o, 64'h8000_0000);
    inst_ready_i = 1'b1;
    nc();
    inst_ready_i = 1'b0;
    chk("f2_arvalid", 64'(mem_arvalid), 64'd1);
    chk("f2_araddr", mem_araddr, 64'h8000_0000);
    chk("f2_instret1", instret_o, 64'd1);
    mem_arready = 1'b1;
    nc();
    mem_arready = 1'b0;
    mem_rvalid = 1'b1;
    nc();
    mem_rvalid = 1'b0;

    // Decode stalls 4 cycles while the second instruction is held
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 64'(inst_valid_o), 64'd1);
      chk("hold_inst", 64'(inst_o), 64'h0000_0093);
      chk("hold_pc", inst_addr_pc_o, 64'h8000_0004);
      chk("hold_arvalid", 64'(mem_arvalid), 64'd0);
      chk("hold_instret", instret_o, 64'd1);
      nc();
    end
    chk("hold_valid_last", 64'(inst_valid_o), 64'd1);

    // Accept with redirect to 0x80000100
    inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0100;
    nc();
    inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;
    chk("redir_instret2", instret_o, 64'd2);
    chk("redir_arvalid", 64'(mem_arvalid), 64'd1);
    chk("redir_araddr", mem_araddr, 64'h8000_0100);
    mem_arready = 1'b1;
    nc();
    mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hdeadbeef_0000006f;
    nc();
    mem_rvalid = 1'b0;
    chk("redir_inst", 64'(inst_o), 64'h0000_006f);
    chk("redir_pc", inst_addr_pc_o, 64'h8000_0100);
    inst_ready_i = 1'b1;
    nc();
    inst_ready_i = 1'b0;
    chk("seq_araddr", mem_araddr, 64'h8000_0100);
    chk("seq_instret3", instret_o, 64'd3);

    // Error response
    mem_arready = 1'b1;
    nc();
    mem_arready = 1'b0;
    mem_rvalid = 1'b1; mem_rresp = 2'b10;
    nc();
    mem_rvalid = 1'b0; mem_rresp = 2'b00;
    chk("err_flag", 64'(fetch_err_o), 64'd1);
    chk("err_nop", 64'(inst_o), 64'h0000_0013);
    mem_arready = 1'b1; inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("err_ivalid", 64'(inst_valid_o), 64'd0);
      chk("err_arvalid", 64'(mem_arvalid), 64'd0);
      chk("err_rready", 64'(mem_rready), 64'd0);
      chk("err_sticky", 64'(fetch_err_o), 64'd1);
      nc();
    end
    inst_ready_i = 1'b0;
    rst = 1'b1;
    nc();
    chk("erst_pc", inst_addr_pc_o, 64'h8000_0000);
    chk("erst_araddr", mem_araddr, 64'h8000_0000);
    chk("erst_err", 64'(fetch_err_o), 64'd0);
    chk("erst_instret", instret_o, 64'd0);

    // Misaligned redirect to 0x80000102
    rst = 1'b0;
    nc();
    chk("mis_arvalid", 64'(mem_arvalid), 64'd1);
    nc();
    mem_arready = 1'b0;
    chk("mis_rready", 64'(mem_rready), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 64'h00000093_00100113;
    nc();
    mem_rvalid = 1'b0;
    chk("mis_inst", 64'(inst_o), 64'h0010_0113);
    inst_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h8000_0102;
    nc();
    inst_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 64'h0;
    mem_arready = 1'b1;
    chk("mis_err", 64'(fetch_err_o), 64'd1);
    chk("mis_arvalid0", 64'(mem_arvalid), 64'd0);
    chk("mis_araddr", mem_araddr, 64'h8000_0100);
    chk("mis_instret", instret_o, 64'd1);
    nc();
    chk("mis_arvalid1", 64'(mem_arvalid), 64'd0);
    chk("mis_ivalid", 64'(inst_valid_o), 64'd0);
    mem_arready = 1'b0;

    // Reset while a read is outstanding
    rst = 1'b1;
    nc();
    rst = 1'b0; mem_arready = 1'b1;
    nc();
    nc();
    mem_arready = 1'b0;
    chk("wrst_in_wait", 64'(mem_rready), 64'd1);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h11111111_22222222;
    nc();
    rst = 1'b0;
    chk("wrst_rready", 64'(mem_rready), 64'd0);
    chk("wrst_ivalid", 64'(inst_valid_o), 64'd0);
    chk("wrst_araddr", mem_araddr, 64'h8000_0000);
    chk("wrst_instret", instret_o, 64'd0);
    nc();
    mem_rvalid = 1'b0;
    chk("late_rvalid_ign_ivalid", 64'(inst_valid_o), 64'd0);
    chk("late_rvalid_ign_arvalid", 64'(mem_arvalid), 64'd1);
    chk("late_rvalid_ign_inst", 64'(inst_o), 64'd0);
    nc();
    chk("late_still_req", 64'(mem_arvalid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
